// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its downstream BCD stage.
package fib_pkg;

    localparam int FIB_BIN_W      = 20;
    localparam int FIB_BCD_DIGITS = 7;
    localparam int FIB_TAG_W      = 8;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fib_bcd_state_t;

endpackage

// File: rtl/fib_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module fib_bcd_digit_adj (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // 5..9 maps to 8..12, so the 4-bit sum never carries out.
    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/fibonacci_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), valid/ready on both sides.
// Define FIB_BCD_BLANK_EN to replace leading zero digits with the blank code.
module fibonacci_bcd_converter
    import fib_pkg::*;
#(
    parameter int BIN_W  = FIB_BIN_W,
    parameter int DIGITS = FIB_BCD_DIGITS,
    parameter int TAG_W  = FIB_TAG_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic [TAG_W-1:0]    tag_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [TAG_W-1:0]    tag_out,
    output logic                busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       state;
    logic [SR_W-1:0]  shift_reg;
    logic [SR_W-1:0]  adjusted;
    logic [SR_W-1:0]  shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic [TAG_W-1:0] tag_reg;
    logic [BCD_W-1:0] raw_bcd;
    logic [BCD_W-1:0] final_bcd;

    // Only the BCD field is corrected; the binary part just shifts through.
    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_adj
            fib_bcd_digit_adj u_adj (
                .nib_in  (shift_reg[BIN_W + 4*d +: 4]),
                .nib_out (adjusted[BIN_W + 4*d +: 4])
            );
        end
    endgenerate

    assign adjusted[BIN_W-1:0] = shift_reg[BIN_W-1:0];
    assign shifted             = adjusted << 1;
    assign raw_bcd             = shifted[SR_W-1 -: BCD_W];

`ifdef FIB_BCD_BLANK_EN
    always_comb begin
        logic leading;
        // NOTE: every variable gets a default before the loop, otherwise a latch is inferred.
        final_bcd = raw_bcd;
        leading   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && raw_bcd[4*i +: 4] == 4'd0) begin
                final_bcd[4*i +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign final_bcd = raw_bcd;
`endif

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_SHIFT) || (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the shift register is plain flops, not a memory, so it is reset along with the rest.
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tag_reg   <= '0;
            bcd_out   <= '0;
            tag_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shift_reg <= {{BCD_W{1'b0}}, bin_in};
                        tag_reg   <= tag_in;
                        bit_cnt   <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shifted;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    // Output fields change only here, so they stay stable through DONE.
                    if (bit_cnt == LAST_BIT) begin
                        bcd_out   <= final_bcd;
                        tag_out   <= tag_reg;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_bcd_converter.sv
// Self-checking bench: directed and random conversions against a decimal reference model.
module tb_fibonacci_bcd_converter;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] bin_in;
    logic [7:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] bcd_out;
    logic [7:0]  tag_out;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    fibonacci_bcd_converter dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Decimal digits by division; blank build replaces digits above the most significant one.
    function automatic logic [27:0] ref_bcd(input int unsigned v);
        int unsigned r;
        int          nd;
        logic [27:0] b;
        b = '0;
        r = v;
        for (int i = 0; i < 7; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef FIB_BCD_BLANK_EN
        r  = v;
        nd = 1;
        while (r >= 10) begin
            r = r / 10;
            nd++;
        end
        for (int i = nd; i < 7; i++) b[4*i +: 4] = 4'hF;
`else
        nd = 0;
`endif
        return b;
    endfunction

    // Called right after a falling edge; returns right after a falling edge.
    task automatic convert(input logic [19:0] bin, input logic [7:0] tag,
                           input int stall, output int acc);
        int          n;
        int          lat;
        int          changes;
        logic [27:0] exp;
        exp = ref_bcd(int'(bin));
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        bin_in    = bin;
        tag_in    = tag;
        out_ready = (stall == 0);
        @(negedge clock);
        acc      = cyc;
        in_valid = 1'b0;
        bin_in   = 20'($urandom);
        tag_in   = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'd20);
        check("bcd_out", 32'(bcd_out), 32'(exp));
        check("tag_out", 32'(tag_out), 32'(tag));
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        if (stall > 0) begin
            changes  = 0;
            in_valid = 1'b1;
            repeat (stall) begin
                @(negedge clock);
                if (bcd_out !== exp || tag_out !== tag || out_valid !== 1'b1 || in_ready !== 1'b0)
                    changes++;
            end
            check("stall_stable", 32'(changes), 32'd0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clock);
        check("retired_valid", 32'(out_valid), 32'd0);
        check("retired_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          a0;
        int          a1;
        int          fa;
        int          fb;
        int          ft;
        int          seen;
        logic [19:0] rv;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bin_in    = '0;
        tag_in    = '0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_tag", 32'(tag_out), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        convert(20'd6765, 8'd20, 0, a0);

        convert(20'd0, 8'd1, 0, a0);
        convert(20'd1048575, 8'd2, 0, a1);
        check("b2b_spacing", 32'(a1 - a0), 32'd22);

        convert(20'd75025, 8'd25, 10, a0);

        fa = 0;
        fb = 1;
        for (int k = 1; k <= 30; k++) begin
            convert(20'(fb), 8'(k), int'($urandom_range(0, 3)), a0);
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end

        for (int k = 0; k < 12; k++) begin
            rv = 20'($urandom);
            convert(rv, 8'($urandom), int'($urandom_range(0, 2)), a0);
        end

        // Abort mid-conversion; previous bcd_out is nonzero so the reset clear is observable.
        in_valid = 1'b1;
        bin_in   = 20'd12345;
        tag_in   = 8'd9;
        @(posedge clock);
        repeat (7) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        check("abort_tag", 32'(tag_out), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        convert(20'd832040, 8'd30, 0, a0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
